open_risc_v: RTL and testbench

OPEN_RISC_V -- requirements
Module: open_risc_v

---
 rtl/open_risc_v.sv | 231 +++++++++++++++++++++++
 tb/tb_open_risc_v.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/open_risc_v.sv
// Three-stage RV32I core (IF / ID / EX) with separate instruction and data memories.
// No stalls. Taken control flow resolves in EX and squashes the two younger slots.
module open_risc_v #(
    parameter int unsigned IMEM_DEPTH = 4096,
    parameter int unsigned DMEM_DEPTH = 4096
) (
    input logic sys_clk,
    input logic sys_rst_n
);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc_q;
    logic [31:0] id_instr_q, id_pc_q;
    logic [31:0] ex_instr_q, ex_pc_q, ex_rs1_q, ex_rs2_q;
    logic [31:0] if_instr;
    logic [31:0] rf_rd1, rf_rd2, id_rs1_val, id_rs2_val;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // ---------------- IF ----------------
    if (1) begin : instruction_fetch_inst
        if (1) begin : instruction_memory
            // Read-only to the core; filled by the environment, NOP elsewhere.
            logic [31:0] inst_mem [0:IMEM_DEPTH-1] = '{default: 32'h0000_0013};
        end
        assign if_instr = instruction_memory.inst_mem[pc_q[IAW+1:2]];
    end

    // ---------------- Register file ----------------
    if (1) begin : register_file_inst
        logic [31:0] reg_mem [0:31];

        // Async clear on reset; EX writeback at the closing edge (wb_en excludes x0).
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                for (int i = 0; i < 32; i++) reg_mem[i] <= '0;
            end else if (wb_en) begin
                reg_mem[wb_rd] <= wb_data;
            end
        end

        assign rf_rd1 = reg_mem[id_instr_q[19:15]];
        assign rf_rd2 = reg_mem[id_instr_q[24:20]];
    end

    // ---------------- ID: register read with EX bypass ----------------
    logic [4:0] id_rs1, id_rs2;
    assign id_rs1 = id_instr_q[19:15];
    assign id_rs2 = id_instr_q[24:20];

    // Forward the value EX writes this cycle so dependent instructions never stall.
    always_comb begin
        id_rs1_val = rf_rd1;
        id_rs2_val = rf_rd2;
        if (id_rs1 == 5'd0)                 id_rs1_val = '0;
        else if (wb_en && wb_rd == id_rs1) id_rs1_val = wb_data;
        if (id_rs2 == 5'd0)                 id_rs2_val = '0;
        else if (wb_en && wb_rd == id_rs2) id_rs2_val = wb_data;
    end

    // ---------------- EX: decode ----------------
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ex_instr_q[6:0];
    assign rd     = ex_instr_q[11:7];
    assign f3     = ex_instr_q[14:12];
    assign f7     = ex_instr_q[31:25];
    assign imm_i  = {{20{ex_instr_q[31]}}, ex_instr_q[31:20]};
    assign imm_s  = {{20{ex_instr_q[31]}}, ex_instr_q[31:25], ex_instr_q[11:7]};
    assign imm_b  = {{19{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[7], ex_instr_q[30:25],
                     ex_instr_q[11:8], 1'b0};
    assign imm_u  = {ex_instr_q[31:12], 12'b0};
    assign imm_j  = {{11{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[19:12], ex_instr_q[20],
                     ex_instr_q[30:21], 1'b0};

    // Undefined encodings fall through every *_ok term and behave as NOPs.
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opimm, is_op;
    assign is_lui   = opcode == OPC_LUI;
    assign is_auipc = opcode == OPC_AUIPC;
    assign is_jal   = opcode == OPC_JAL;
    assign is_jalr  = opcode == OPC_JALR && f3 == 3'd0;
    assign is_br    = opcode == OPC_BRANCH && f3 != 3'd2 && f3 != 3'd3;
    assign is_ld    = opcode == OPC_LOAD && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                             f3 == 3'd4 || f3 == 3'd5);
    assign is_st    = opcode == OPC_STORE && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    assign is_op    = opcode == OPC_OP &&
                      (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    assign is_opimm = opcode == OPC_OPIMM &&
                      ((f3 == 3'd1) ? (f7 == 7'h00) :
                       (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);

    // ---------------- EX: ALU ----------------
    logic [31:0] alu_b, alu_res;

    // Shared ALU for OP and OP-IMM; f7[5] selects SUB (OP only) and SRA.
    always_comb begin
        alu_b   = is_op ? ex_rs2_q : imm_i;
        alu_res = '0;
        case (f3)
            3'd0: alu_res = (is_op && f7[5]) ? ex_rs1_q - alu_b : ex_rs1_q + alu_b;
            3'd1: alu_res = ex_rs1_q << alu_b[4:0];
            3'd2: alu_res = {31'b0, $signed(ex_rs1_q) < $signed(alu_b)};
            3'd3: alu_res = {31'b0, ex_rs1_q < alu_b};
            3'd4: alu_res = ex_rs1_q ^ alu_b;
            3'd5: alu_res = f7[5] ? 32'($signed(ex_rs1_q) >>> alu_b[4:0])
                                  : ex_rs1_q >> alu_b[4:0];
            3'd6: alu_res = ex_rs1_q | alu_b;
            default: alu_res = ex_rs1_q & alu_b;
        endcase
    end

    // ---------------- EX: branch resolve ----------------
    logic        br_cond, redirect;
    logic [31:0] target;

    // Branch condition from funct3.
    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'd0: br_cond = ex_rs1_q == ex_rs2_q;
            3'd1: br_cond = ex_rs1_q != ex_rs2_q;
            3'd4: br_cond = $signed(ex_rs1_q) < $signed(ex_rs2_q);
            3'd5: br_cond = $signed(ex_rs1_q) >= $signed(ex_rs2_q);
            3'd6: br_cond = ex_rs1_q < ex_rs2_q;
            3'd7: br_cond = ex_rs1_q >= ex_rs2_q;
            default: br_cond = 1'b0;
        endcase
    end

    assign redirect = (is_br && br_cond) || is_jal || is_jalr;
    assign target   = is_jalr ? ((ex_rs1_q + imm_i) & ~32'd1) :
                      is_jal  ? (ex_pc_q + imm_j) : (ex_pc_q + imm_b);

    // ---------------- EX: data memory ----------------
    logic [31:0] data_mem [0:DMEM_DEPTH-1] = '{default: 32'h0};
    logic [31:0] mem_addr, dm_rdata, ld_shift, ld_val, st_wdata;
    logic [3:0]  st_be;
    logic        unused_addr_hi;

    assign mem_addr       = ex_rs1_q + (is_st ? imm_s : imm_i);
    assign dm_rdata       = data_mem[mem_addr[DAW+1:2]];
    assign ld_shift       = dm_rdata >> {mem_addr[1:0], 3'b000};
    assign st_wdata       = (f3 == 3'd2) ? ex_rs2_q : ex_rs2_q << {mem_addr[1:0], 3'b000};
    assign st_be          = (f3 == 3'd0) ? 4'b0001 << mem_addr[1:0] :
                            (f3 == 3'd1) ? 4'b0011 << mem_addr[1:0] : 4'b1111;
    assign unused_addr_hi = ^mem_addr[31:DAW+2];

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        ld_val = '0;
        case (f3)
            3'd0: ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1: ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd2: ld_val = dm_rdata;
            3'd4: ld_val = {24'b0, ld_shift[7:0]};
            3'd5: ld_val = {16'b0, ld_shift[15:0]};
            default: ld_val = '0;
        endcase
    end

    // Byte-enabled store at the EX edge; reset never clears contents.
    always_ff @(posedge sys_clk) begin
        if (is_st) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data_mem[mem_addr[DAW+1:2]][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- EX: writeback select ----------------
    assign wb_rd = rd;
    assign wb_en = (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_op || is_opimm) &&
                   rd != 5'd0;

    // Result mux by opcode.
    always_comb begin
        wb_data = alu_res;
        case (opcode)
            OPC_LUI:            wb_data = imm_u;
            OPC_AUIPC:          wb_data = ex_pc_q + imm_u;
            OPC_JAL, OPC_JALR:  wb_data = ex_pc_q + 32'd4;
            OPC_LOAD:           wb_data = ld_val;
            default:            wb_data = alu_res;
        endcase
    end

    // ---------------- Pipeline registers ----------------
    // PC advance and stage handoff; a redirect squashes IF and ID to NOP.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pc_q       <= '0;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
            ex_instr_q <= NOP;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            ex_pc_q  <= id_pc_q;
            ex_rs1_q <= id_rs1_val;
            ex_rs2_q <= id_rs2_val;
            id_pc_q  <= pc_q;
            if (redirect) begin
                pc_q       <= target;
                id_instr_q <= NOP;
                ex_instr_q <= NOP;
            end else begin
                pc_q       <= pc_q + 32'd4;
                id_instr_q <= if_instr;
                ex_instr_q <= id_instr_q;
            end
        end
    end

endmodule

// File: tb/tb_open_risc_v.sv
// Scoreboard bench: each program pushes its expected writebacks (rd, data) in order;
// a monitor pops one entry per retired register write and compares.
module tb_open_risc_v;
    localparam logic [6:0] OPI = 7'h13, LDO = 7'h03, JLR = 7'h67, LUI = 7'h37, AUI = 7'h17;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    open_risc_v dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         exp_q[$];
    logic [31:0] prog[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: compare every retired register write against the queue head.
    always @(negedge sys_clk) begin
        if (mon_on && sys_rst_n && dut.wb_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wb: got x%0d=%08h expected none", dut.wb_rd,
                         dut.wb_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_rd", {27'b0, dut.wb_rd}, {27'b0, e.rd});
                check("wb_data", dut.wb_data, e.data);
            end
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [11:0] im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [12:0] im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] xreg(input int i);
        return dut.register_file_inst.reg_mem[i];
    endfunction

    task automatic expect_wb(input int rd, input logic [31:0] d);
        exp_q.push_back(wb_t'{rd: rd[4:0], data: d});
    endtask

    // Hold reset, load the image, arm the monitor and release on a falling edge.
    task automatic start_run();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        mon_on    = 1'b0;
        repeat (2) @(negedge sys_clk);
        for (int k = 0; k < 64; k++)
            dut.instruction_fetch_inst.instruction_memory.inst_mem[k] = 32'h13;
        foreach (prog[k]) dut.instruction_fetch_inst.instruction_memory.inst_mem[k] = prog[k];
        mon_on    = 1'b1;
        sys_rst_n = 1'b1;
    endtask

    task automatic end_run(input string name, input int cycles);
        repeat (cycles) @(posedge sys_clk);
        #1;
        mon_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d outstanding writebacks expected 0", name,
                     exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic load_p5();
        prog = {enc_i(-8, 0, 0, 1, OPI),          // addi x1,x0,-8
                enc_i(32'h401, 1, 5, 2, OPI),     // srai x2,x1,1
                enc_i(28, 1, 5, 3, OPI),          // srli x3,x1,28
                enc_r(0, 3, 1, 2, 4),             // slt  x4,x1,x3
                enc_r(0, 3, 1, 3, 5),             // sltu x5,x1,x3
                enc_r(32, 1, 3, 0, 6),            // sub  x6,x3,x1
                enc_u(32'h12345, 7, LUI),         // lui  x7,0x12345
                enc_i(-1, 7, 4, 8, OPI),          // xori x8,x7,-1
                enc_u(1, 9, AUI),                 // auipc x9,1 (pc 32)
                enc_r(0, 3, 3, 1, 10),            // sll  x10,x3,x3
                enc_r(0, 7, 3, 6, 11),            // or   x11,x3,x7
                enc_r(0, 7, 8, 7, 12),            // and  x12,x8,x7
                enc_i(16, 3, 3, 13, OPI),         // sltiu x13,x3,16
                enc_b(8, 1, 1, 1),                // bne  x1,x1,+8 (not taken)
                enc_b(8, 0, 1, 4),                // blt  x1,x0,+8 (taken)
                enc_i(1, 0, 0, 14, OPI),          // addi x14 (squashed)
                enc_i(7, 0, 0, 15, OPI),          // addi x15,x0,7
                32'h0000_0073,                    // ecall
                enc_i(32'h300, 1, 1, 16, 7'h73)}; // csrrw x16 -> NOP
    endtask

    task automatic expect_p5();
        expect_wb(1, 32'hFFFF_FFF8);  expect_wb(2, 32'hFFFF_FFFC);  expect_wb(3, 32'h0000_000F);
        expect_wb(4, 32'h1);          expect_wb(5, 32'h0);          expect_wb(6, 32'h17);
        expect_wb(7, 32'h1234_5000);  expect_wb(8, 32'hEDCB_AFFF);  expect_wb(9, 32'h1020);
        expect_wb(10, 32'h0007_8000); expect_wb(11, 32'h1234_500F); expect_wb(12, 32'h0);
        expect_wb(13, 32'h1);         expect_wb(15, 32'h7);
    endtask

    task automatic check_p5_regs(input string tag);
        check({tag, "_x2"}, xreg(2), 32'hFFFF_FFFC);
        check({tag, "_x6"}, xreg(6), 32'h17);
        check({tag, "_x10"}, xreg(10), 32'h0007_8000);
        check({tag, "_x14"}, xreg(14), 32'h0);
        check({tag, "_x15"}, xreg(15), 32'h7);
        check({tag, "_x16"}, xreg(16), 32'h0);
    endtask

    initial begin
        // Bypass chain, no stall.
        prog = {enc_i(5, 0, 0, 1, OPI), enc_i(3, 1, 0, 2, OPI), enc_r(0, 2, 1, 0, 3)};
        start_run();
        expect_wb(1, 32'd5); expect_wb(2, 32'd8); expect_wb(3, 32'd13);
        end_run("bypass", 20);
        check("bypass_x3", xreg(3), 32'd13);

        // Byte/halfword lanes and extension.
        prog = {enc_i(-1, 0, 0, 1, OPI), enc_s(8, 1, 0, 2), enc_s(9, 0, 0, 0),
                enc_i(8, 0, 2, 2, LDO), enc_i(11, 0, 4, 3, LDO), enc_i(8, 0, 1, 4, LDO),
                enc_s(14, 1, 0, 1), enc_i(14, 0, 5, 5, LDO), enc_i(11, 0, 0, 6, LDO)};
        start_run();
        expect_wb(1, 32'hFFFF_FFFF); expect_wb(2, 32'hFFFF_00FF); expect_wb(3, 32'hFF);
        expect_wb(4, 32'hFF);        expect_wb(5, 32'hFFFF);      expect_wb(6, 32'hFFFF_FFFF);
        end_run("mem", 25);
        check("dmem_w2", dut.data_mem[2], 32'hFFFF_00FF);
        check("dmem_w3", dut.data_mem[3], 32'hFFFF_0000);

        // Taken branch squashes both younger slots; reset also cleared old regs.
        prog = {enc_b(12, 0, 0, 0), enc_i(1, 0, 0, 5, OPI), enc_i(1, 0, 0, 6, OPI),
                enc_i(1, 0, 0, 7, OPI)};
        start_run();
        expect_wb(7, 32'd1);
        end_run("branch", 20);
        check("branch_x5", xreg(5), 32'd0);
        check("branch_x6", xreg(6), 32'd0);

        // JAL / JALR loop.
        prog = {enc_j(8, 1), enc_i(1, 0, 0, 5, OPI), enc_i(0, 1, 0, 2, JLR)};
        start_run();
        expect_wb(1, 32'd4); expect_wb(2, 32'd12); expect_wb(5, 32'd1);
        expect_wb(2, 32'd12); expect_wb(5, 32'd1);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge sys_clk);
        end_run("jump", 0);

        // ALU mix, shifts, compares, LUI/AUIPC, system ops as NOPs.
        load_p5();
        start_run();
        expect_p5();
        end_run("alu", 40);
        check_p5_regs("alu");

        // Mid-run reset aborts everything, then a rerun reproduces the clean result.
        start_run();
        mon_on = 1'b0;
        repeat (8) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        begin
            logic [31:0] acc;
            acc = '0;
            for (int i = 0; i < 32; i++) acc |= xreg(i);
            check("rst_regs_or", acc, 32'h0);
        end
        check("rst_pc", dut.pc_q, 32'h0);
        check("rst_id_instr", dut.id_instr_q, 32'h13);
        check("rst_ex_instr", dut.ex_instr_q, 32'h13);
        start_run();
        expect_p5();
        end_run("rerun", 40);
        check_p5_regs("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end
endmodule
